led_blink_bank: RTL
===================

Name: led_blink_bank

Overview:
- Parametrised multi-channel LED/indicator driver; next generation of the single free-running blink counter.
- A shared prescaler produces a periodic tick. Each channel has its own programmable mode (off / on / blink / one-shot) and half-period in ticks.
- Configuration comes through a single-cycle write port from the board-level controller.
- Drives board LEDs directly and exports an 8-bit TEST_IO debug bus for scope probing.

Parameters:
PRESCALE, 50000, clk cycles per tick (1 ms at 50 MHz); legal range >=1
NUM_CH, 8, number of LED channels; legal range >=1
CNT_W, 16, width of per-channel half-period and tick counter
CH_W, max(1,$clog2(NUM_CH)), width of channel select (derived, not overridden)

Ports:
clk  in  1  system clock (50 MHz board clock)
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  config write strobe, one cycle per write
cfg_ch  in  CH_W  target channel of write
cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT
cfg_half  in  CNT_W  half-period / on-time in ticks; 0 treated as 1
led  out  NUM_CH  per-channel LED drive, registered
tick  out  1  registered one-cycle pulse every PRESCALE clocks
TEST_IO  out  8  debug bus: [0]=tick, [1]=led[0], [2]=led[NUM_CH-1], [3]=any channel in ONESHOT, [7:4]=prescaler count[3:0]

Behaviour:
- Reset (async assert, sync release on clk):
  - prescaler=0, tick=0.
  - All channels: mode=OFF, half=1, cnt=0, led=0.
  - TEST_IO follows from these values.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick is registered high for exactly one cycle on the edge where the prescaler wraps to 0.
  - First tick occurs PRESCALE cycles after reset release.
  - PRESCALE=1: tick is high every cycle.
- Config write (cfg_we=1, cfg_ch<NUM_CH), applied on the next rising edge (1-cycle latency to led):
  - mode<=cfg_mode; half<=(cfg_half==0 ? 1 : cfg_half); cnt<=0.
  - led<=0 for OFF, 1 for ON/BLINK/ONESHOT.
  - cfg_ch>=NUM_CH: write ignored, no state changes.
- Per-channel state machine (advances only on tick cycles):
  - OFF: led=0, cnt held at 0.
  - ON: led=1, cnt held at 0.
  - BLINK: cnt<=cnt+1. When cnt+1==half: led toggles and cnt<=0. Resulting period is 2*half ticks, 50% duty. Stays in BLINK.
  - ONESHOT: cnt<=cnt+1. When cnt+1==half: led<=0, cnt<=0, mode<=OFF. Total on-time is exactly half ticks, counted from the write.
- Arithmetic:
  - cnt is CNT_W bits and never exceeds half-1, so no wrap.
  - half=2^CNT_W-1 is the maximum legal value.
- Simultaneous events:
  - cfg_we to channel k in the same cycle as tick: the write wins for k, and k's tick is discarded that cycle. All other channels process the tick normally.
  - Rewriting a channel mid-blink or mid-oneshot restarts it from cnt=0 with led per the new mode.
- Channels are fully independent. No cross-channel phase alignment is guaranteed except via simultaneous configuration.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous), with no pending ONESHOT completion.

Test Plan (PRESCALE=4, NUM_CH=4, CNT_W=8):
- Reset release, no writes -> led=4'b0000 for 100 cycles; tick high on cycles 4,8,12,... after release, one cycle wide each.
- Write ch1 BLINK half=3 -> led[1]=1 the cycle after the write; led[1] toggles every 3 ticks (12 clk), period 24 clk, for >=5 periods; other leds stay 0.
- Write ch2 ONESHOT half=5 -> led[2]=1 for exactly 5 ticks, then 0 permanently; TEST_IO[3] high during the on-time, then 0.
- Write ch0 BLINK half=0 -> treated as half=1: led[0] toggles on every tick; TEST_IO[1] mirrors led[0].
- cfg_we to ch1 (ON) in the same cycle as tick while ch3 is blinking -> ch1 goes to 1 with no tick effect; ch3 advances normally. Write with cfg_ch=3 when NUM_CH=3 (rerun) -> no state change.
- Assert rst asynchronously mid-ONESHOT and mid-BLINK (between clk edges) -> led=0 and tick=0 immediately. After release, channels stay OFF until rewritten.

Source files
------------

// File: rtl/led_blink_bank.sv
`default_nettype none
// ============================================================================
//  Module      : led_blink_bank
//  Description : Multi-channel LED / indicator driver. A shared prescaler
//                produces a periodic tick; every channel runs its own
//                OFF / ON / BLINK / ONESHOT mode with a programmable
//                half-period counted in ticks. Channels are configured
//                through a single-cycle write port.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1      system clock
//    rst       in   1      asynchronous active-high reset
//    cfg_we    in   1      config write strobe (one cycle per write)
//    cfg_ch    in   CH_W   target channel; values >= NUM_CH are ignored
//    cfg_mode  in   2      0=OFF 1=ON 2=BLINK 3=ONESHOT
//    cfg_half  in   CNT_W  half-period / on-time in ticks (0 acts as 1)
//    led       out  NUM_CH registered per-channel LED drive
//    tick      out  1      registered one-cycle pulse every PRESCALE clocks
//    TEST_IO   out  8      [0]=tick [1]=led[0] [2]=led[NUM_CH-1]
//                          [3]=any channel in ONESHOT [7:4]=prescaler[3:0]
// ============================================================================
module led_blink_bank #(
  parameter int PRESCALE = 50000,
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 16,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] led,
  output logic              tick,
  output logic [7:0]        TEST_IO
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  // --------------------------------------------------------------------------
  // Shared prescaler. tick is registered on the wrap edge, so the first tick
  // appears PRESCALE cycles after reset release; with PRESCALE=1 the counter
  // sits at 0 and tick is asserted every cycle.
  // --------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q,  tick_d;

  always_comb begin
    tick_d  = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick_d ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  // --------------------------------------------------------------------------
  // Per-channel state. Channels advance on the cycle in which tick is high;
  // a write to a channel in that same cycle takes priority and its tick is
  // dropped for that channel only.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] oneshot_vec;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             led_q,  led_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             wr_hit;

    // Out-of-range channel numbers never match any k, so they are ignored.
    assign wr_hit  = cfg_we && (cfg_ch == CH_W'(k));
    // cnt never exceeds half-1 <= 2^CNT_W-2, so this increment cannot wrap.
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
      mode_d = mode_q;
      half_d = half_q;
      cnt_d  = cnt_q;
      led_d  = led_q;
      if (wr_hit) begin
        mode_d = cfg_mode;
        half_d = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
        cnt_d  = '0;
        led_d  = (cfg_mode != MODE_OFF);
      end else if (tick_q) begin
        case (mode_q)
          MODE_OFF: begin
            led_d = 1'b0;
            cnt_d = '0;
          end
          MODE_ON: begin
            led_d = 1'b1;
            cnt_d = '0;
          end
          MODE_BLINK: begin
            if (cnt_inc == half_q) begin
              led_d = ~led_q;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          default: begin  // MODE_ONESHOT
            if (cnt_inc == half_q) begin
              led_d  = 1'b0;
              cnt_d  = '0;
              mode_d = MODE_OFF;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        mode_q <= MODE_OFF;
        half_q <= CNT_W'(1);
        cnt_q  <= '0;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_d;
        half_q <= half_d;
        cnt_q  <= cnt_d;
        led_q  <= led_d;
      end
    end

    assign led[k]         = led_q;
    assign oneshot_vec[k] = (mode_q == MODE_ONESHOT);
  end

  // --------------------------------------------------------------------------
  // Debug bus: low nibble of the prescaler, zero-padded for narrow counters.
  // --------------------------------------------------------------------------
  logic [3:0] dbg_cnt;

  if (PW >= 4) begin : g_dbg_wide
    assign dbg_cnt = presc_q[3:0];
  end else begin : g_dbg_narrow
    assign dbg_cnt = {{(4 - PW){1'b0}}, presc_q};
  end

  assign TEST_IO = {dbg_cnt, |oneshot_vec, led[NUM_CH-1], led[0], tick_q};

endmodule
`default_nettype wire
